// File: rtl/ask_pkg.sv
// Shared types and helpers for the ASK receive path.
package ask_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {
    ALIGN,
    ACCUM,
    DECIDE
  } state_e;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] max_v
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_v}) ? max_v : s[31:0];
  endfunction

endpackage

// File: rtl/ask_rectifier.sv
// Signed sample to unsigned magnitude; the most negative code maps
// to 2^(W-1), which still fits in W unsigned bits.
module abs_rectifier #(
  parameter int W = 12
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] mag_o
);

  assign mag_o = x_i[W-1] ? (~x_i + W'(1)) : x_i;

endmodule

// File: rtl/ask_demodulator.sv
// ASK demodulator: rectify, integrate per bit window, threshold.
// Optional bit-error counter enabled by ASK_DEMOD_BER_EN.
module ask_demodulator
  import ask_pkg::*;
#(
  parameter int MAX_SAMPLES = 4096,
  parameter int ACC_W       = SAMPLE_W + $clog2(MAX_SAMPLES)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_en,
  input  logic [SAMPLE_W-1:0] ask_in,
  input  logic                bit_strobe,
  input  logic [ACC_W-1:0]    thresh,
  input  logic                ref_bit,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                overrun,
  output logic [15:0]         err_count
);

  localparam int CNT_W = $clog2(MAX_SAMPLES) + 1;
  localparam logic [31:0] ACC_MAX =
    32'((64'd1 << ACC_W) - 64'd1);

  state_e              state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                bit_out_q;
  logic                bit_valid_q;
  logic                overrun_q;

  logic [SAMPLE_W-1:0] mag;
  logic [ACC_W-1:0]    mag_ext;
  logic [ACC_W-1:0]    acc_sum;
  logic [CNT_W-1:0]    cnt_inc;
  logic                full;

  abs_rectifier #(.W(SAMPLE_W)) u_rect (
    .x_i   (ask_in),
    .mag_o (mag)
  );

  assign mag_ext = ACC_W'(mag);
  assign acc_sum = ACC_W'(sat_add(32'(acc_q), 32'(mag), ACC_MAX));
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign full    = sample_en && (cnt_inc == CNT_W'(MAX_SAMPLES));

  // Decision registers on the boundary edge; DECIDE then integrates
  // like ACCUM so a back-to-back strobe is still honoured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ALIGN;
      acc_q       <= '0;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      unique case (state_q)
        ALIGN: begin
          if (bit_strobe) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM, DECIDE: begin
          if (bit_strobe) begin
            bit_out_q   <= (acc_q > thresh);
            bit_valid_q <= 1'b1;
            acc_q       <= sample_en ? mag_ext : '0;
            cnt_q       <= sample_en ? CNT_W'(1) : '0;
            state_q     <= DECIDE;
          end else if (full) begin
            bit_out_q   <= (acc_sum > thresh);
            bit_valid_q <= 1'b1;
            overrun_q   <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            state_q     <= DECIDE;
          end else begin
            if (sample_en) begin
              acc_q <= acc_sum;
              cnt_q <= cnt_inc;
            end
            state_q <= ACCUM;
          end
        end
        default: state_q <= ALIGN;
      endcase
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign overrun   = overrun_q;

`ifdef ASK_DEMOD_BER_EN
  logic        ref_q;
  logic        first_q;
  logic [15:0] err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_q   <= 1'b0;
      first_q <= 1'b1;
      err_q   <= '0;
    end else begin
      if (bit_strobe && state_q != ALIGN)
        ref_q <= ref_bit;
      if (state_q == ALIGN) begin
        first_q <= 1'b1;
      end else if (state_q == DECIDE) begin
        first_q <= 1'b0;
        if (!first_q && (bit_out_q != ref_q) && (err_q != 16'hFFFF))
          err_q <= err_q + 16'd1;
      end
    end
  end

  assign err_count = err_q;
`else
  logic unused_ref;
  assign unused_ref = ref_bit;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_ask_demodulator.sv
// Directed bench for ask_demodulator (default and 16-sample instances).
module tb_ask_demodulator;

  logic        clk;
  logic        reset_n;
  logic        sample_en;
  logic [11:0] ask_in;
  logic        bit_strobe;
  logic [23:0] thresh;
  logic        ref_bit;
  logic        bit_out;
  logic        bit_valid;
  logic        overrun;
  logic [15:0] err_count;

  logic        s_en;
  logic [11:0] s_in;
  logic        s_st;
  logic [15:0] s_thresh;
  logic        s_out;
  logic        s_valid;
  logic        s_ov;
  logic [15:0] s_err;

  int nvec = 0;
  int nerr = 0;
  logic seen;

  ask_demodulator u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_en  (sample_en),
    .ask_in     (ask_in),
    .bit_strobe (bit_strobe),
    .thresh     (thresh),
    .ref_bit    (ref_bit),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .overrun    (overrun),
    .err_count  (err_count)
  );

  ask_demodulator #(.MAX_SAMPLES(16)) u_small (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_en  (s_en),
    .ask_in     (s_in),
    .bit_strobe (s_st),
    .thresh     (s_thresh),
    .ref_bit    (1'b0),
    .bit_out    (s_out),
    .bit_valid  (s_valid),
    .overrun    (s_ov),
    .err_count  (s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit se, input int s, input bit st);
    sample_en  = se;
    ask_in     = 12'(s);
    bit_strobe = st;
    @(posedge clk);
    #1;
    sample_en  = 1'b0;
    ask_in     = '0;
    bit_strobe = 1'b0;
  endtask

  task automatic win(input int n, input int v, input bit alt);
    for (int i = 0; i < n; i++)
      cyc(1'b1, (alt && i[0]) ? -v : v, 1'b0);
  endtask

  task automatic scyc(input bit se, input int s, input bit st);
    s_en = se;
    s_in = 12'(s);
    s_st = st;
    @(posedge clk);
    #1;
    s_en = 1'b0;
    s_in = '0;
    s_st = 1'b0;
  endtask

  logic [10:0] bits;
  logic [10:0] inv;

  initial begin
    reset_n = 1'b0; sample_en = 0; ask_in = '0; bit_strobe = 0;
    thresh = '0; ref_bit = 0;
    s_en = 0; s_in = '0; s_st = 0; s_thresh = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_bit_out", bit_out, 1'b0);
    chk1("rst_bit_valid", bit_valid, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    chk16("rst_err", err_count, 16'd0);
    reset_n = 1'b1;

    // samples before the first strobe never decide
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1500, 1'b0);
      seen |= bit_valid;
    end
    cyc(1'b0, 0, 1'b1);
    seen |= bit_valid;
    chk1("align_no_valid", seen, 1'b0);

    // keyed window, 100 x |1000| = 100000
    thresh = 24'd50000;
    win(100, 1000, 1'b1);
    cyc(1'b0, 0, 1'b1);
    chk1("keyed_valid", bit_valid, 1'b1);
    chk1("keyed_bit", bit_out, 1'b1);
    cyc(1'b0, 0, 1'b0);
    chk1("valid_pulse_end", bit_valid, 1'b0);

    win(100, 0, 1'b0);
    cyc(1'b0, 0, 1'b1);
    chk1("zero_valid", bit_valid, 1'b1);
    chk1("zero_bit", bit_out, 1'b0);

    // acc == thresh decides 0, one below decides 1
    win(50, 1000, 1'b0);
    cyc(1'b0, 0, 1'b1);
    chk1("eq_thresh_bit", bit_out, 1'b0);
    thresh = 24'd49999;
    win(50, 1000, 1'b0);
    cyc(1'b0, 0, 1'b1);
    chk1("thresh_m1_bit", bit_out, 1'b1);

    // strobe-cycle sample goes to the next window
    thresh = 24'd10000;
    win(10, 1000, 1'b0);
    cyc(1'b1, -2048, 1'b1);
    chk1("collide_close", bit_out, 1'b0);
    thresh = 24'd2047;
    cyc(1'b0, 0, 1'b1);
    chk1("collide_seed", bit_out, 1'b1);
    thresh = 24'd0;
    cyc(1'b0, 0, 1'b1);
    chk1("silent_thr0", bit_out, 1'b0);

    // back-to-back strobes
    thresh = 24'd499;
    cyc(1'b1, 500, 1'b1);
    chk1("b2b_1_valid", bit_valid, 1'b1);
    chk1("b2b_1_bit", bit_out, 1'b0);
    cyc(1'b0, 0, 1'b1);
    chk1("b2b_2_valid", bit_valid, 1'b1);
    chk1("b2b_2_bit", bit_out, 1'b1);
    cyc(1'b0, 0, 1'b1);
    chk1("b2b_3_bit", bit_out, 1'b0);

    // reset mid-window discards the partial sum
    thresh = 24'd0;
    win(5, 2000, 1'b0);
    cyc(1'b0, 0, 1'b1);
    chk1("pre_rst_bit", bit_out, 1'b1);
    win(3, 2000, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk1("midrst_bit_out", bit_out, 1'b0);
    chk1("midrst_valid", bit_valid, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1'b0, 0, 1'b1);
    chk1("realign_no_valid", bit_valid, 1'b0);
    thresh = 24'd300;
    win(3, 100, 1'b0);
    cyc(1'b0, 0, 1'b1);
    chk1("postrst_valid", bit_valid, 1'b1);
    chk1("postrst_bit", bit_out, 1'b0);

    // overrun on the 16-sample instance
    s_thresh = 16'd10000;
    scyc(1'b0, 0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      scyc(1'b1, 1000, 1'b0);
      seen |= s_valid;
    end
    chk1("ovr_no_early", seen, 1'b0);
    chk1("ovr_not_yet", s_ov, 1'b0);
    scyc(1'b1, 1000, 1'b0);
    chk1("ovr_valid", s_valid, 1'b1);
    chk1("ovr_set", s_ov, 1'b1);
    chk1("ovr_bit", s_out, 1'b1);
    scyc(1'b0, 0, 1'b1);
    scyc(1'b0, 0, 1'b1);
    chk1("ovr_sticky", s_ov, 1'b1);
    chk1("main_no_ovr", overrun, 1'b0);

    // BER: window 0 is excluded, 2/5/8 carry a wrong reference
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk1("ovr_cleared", s_ov, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    thresh = 24'd2000;
    bits = 11'b01101001101;
    inv  = 11'b00100100101;
    cyc(1'b0, 0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      win(4, bits[i] ? 1000 : 0, 1'b0);
      ref_bit = bits[i] ^ inv[i];
      cyc(1'b0, 0, 1'b1);
      ref_bit = 1'b0;
      chk1($sformatf("ber_bit%0d", i), bit_out, bits[i]);
    end
    cyc(1'b0, 0, 1'b0);
`ifdef ASK_DEMOD_BER_EN
    chk16("ber_count", err_count, 16'd3);
`else
    chk16("ber_count", err_count, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
